// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 core definitions (opcodes, canonical NOP, fetch FSM states).
package rv_pkg;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_INSTR = {25'b0, OPC_OP_IMM};
  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, buffering fetched {instr, pc} pairs.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_comb begin
    rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
    wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch stage - owns the PC, issues credit-limited imem requests,
// buffers responses and hands instructions to decode; redirects flush and drain stale responses.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_instr,
  output logic [6:0]       dec_opcode,
  output logic [XLEN-1:0]  dec_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 32 + XLEN;
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc;
  logic [CW-1:0] out_q, out_d, fifo_cnt;
  logic run_q;
  logic req_fire, rsp_ok, push, pop, fifo_full, fifo_empty;
  logic [CW:0] inflight;
  logic [EW-1:0] head;
  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({imem_rsp_data, rsp_pc}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );
  // run_q holds off issue for the first cycle after reset so req_valid reads 0 during reset
  assign inflight       = {1'b0, out_q} + {1'b0, fifo_cnt};
  assign imem_req_valid = run_q && state_q == FETCH && inflight < (CW+1)'(FIFO_DEPTH) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && out_q != '0;
  // responses return in order, so the responder is the oldest outstanding request
  assign rsp_pc         = pc_q - XLEN'({out_q, 2'b00});
  assign push           = rsp_ok && state_q == FETCH && !redirect_valid && !fifo_full;
  assign dec_valid      = !fifo_empty;
  assign pop            = dec_valid && dec_ready;
  assign dec_instr      = fifo_empty ? NOP_INSTR : head[EW-1 -: 32];
  assign dec_opcode     = dec_instr[6:0];
  assign dec_pc         = fifo_empty ? '0 : head[XLEN-1:0];
  always_comb begin
    out_d   = out_q + CW'(req_fire) - CW'(rsp_ok);
    pc_d    = redirect_valid ? (redirect_pc & ~XLEN'(3)) : req_fire ? pc_q + XLEN'(4) : pc_q;
    state_d = (redirect_valid || state_q == DRAIN) ? (out_d != '0 ? DRAIN : FETCH) : FETCH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      run_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a 1-cycle in-order imem model and logs of
// issued requests and consumed instructions.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic dec_valid, dec_ready = 1'b1;
  logic [31:0] dec_instr, dec_pc;
  logic [6:0] dec_opcode;
  logic rsp_en = 1'b1;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] req_log[$], got_pc[$], got_ins[$], got_op[$], pend[$];
  logic [31:0] e, base;
  logic found;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_opcode(dec_opcode), .dec_pc(dec_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [6:0] op;
    op = (a[3:2] == 2'd0) ? 7'h13 : (a[3:2] == 2'd1) ? 7'h03 : (a[3:2] == 2'd2) ? 7'h23 : 7'h33;
    return {a[26:2], op};
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    if (dec_valid && dec_ready) begin
      got_pc.push_back(dec_pc);
      got_ins.push_back(dec_instr);
      got_op.push_back({25'b0, dec_opcode});
    end
    @(posedge clk);
    #1;
    if (acc) begin
      pend.push_back(a);
      req_log.push_back(a);
    end
    if (rsp_en && pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = instr_of(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    req_log.delete();
    got_pc.delete();
    got_ins.delete();
    got_op.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_dec_valid"}, {31'b0, dec_valid}, 32'd0);
    chk({tag, "_dec_instr"}, dec_instr, 32'h0000_0013);
    chk({tag, "_dec_opcode"}, {25'b0, dec_opcode}, 32'h13);
    chk({tag, "_dec_pc"}, dec_pc, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #1;
    chk_reset_outputs("rst");
    run(2);
    rst_n = 1'b1;
    clear_logs();
    // 1: sequential fetch from RESET_PC
    run(30);
    for (int i = 0; i < 6; i++) begin
      e = instr_of(32'(4 * i));
      chk("t1_req_addr", qat(req_log, i), 32'(4 * i));
      chk("t1_dec_pc", qat(got_pc, i), 32'(4 * i));
      chk("t1_dec_instr", qat(got_ins, i), e);
      chk("t1_dec_opcode", qat(got_op, i), {25'b0, e[6:0]});
    end
    // 2: decode stall fills the buffer and holds the head
    base = got_pc[$] + 32'd4;
    clear_logs();
    dec_ready = 1'b0;
    run(10);
    #1;
    e = instr_of(base);
    chk("t2_consumed_none", got_pc.size(), 32'd0);
    chk("t2_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_dec_pc_held", dec_pc, base);
    chk("t2_dec_instr_held", dec_instr, e);
    chk("t2_dec_opcode", {25'b0, dec_opcode}, {25'b0, e[6:0]});
    dec_ready = 1'b1;
    run(20);
    for (int i = 0; i < 6; i++) chk("t2_resume_pc", qat(got_pc, i), base + 32'(4 * i));
    // 3: redirect with two requests outstanding
    rsp_en = 1'b0;
    run(6);
    #1;
    chk("t3_outstanding", pend.size(), 32'd2);
    chk("t3_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    rsp_en = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_d1_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t3_d1_dec_valid", {31'b0, dec_valid}, 32'd0);
    tick();
    #1;
    chk("t3_d2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t3_d2_dec_valid", {31'b0, dec_valid}, 32'd0);
    tick();
    #1;
    chk("t3_fetch_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t3_fetch_addr", imem_req_addr, 32'h100);
    run(10);
    chk("t3_req0", qat(req_log, 0), 32'h100);
    chk("t3_pc0", qat(got_pc, 0), 32'h100);
    chk("t3_ins0", qat(got_ins, 0), instr_of(32'h100));
    chk("t3_pc1", qat(got_pc, 1), 32'h104);
    // 4: redirect coinciding with a decode handshake and a response
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (dec_valid && imem_rsp_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t4_found_overlap", {31'b0, found}, 32'd1);
    base = got_pc[$] + 32'd4;
    chk("t4_head_in_order", dec_pc, base);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("t4_head_consumed", got_pc[$], base);
    #1;
    chk("t4_no_dec_after_redirect", {31'b0, dec_valid}, 32'd0);
    clear_logs();
    run(15);
    chk("t4_req0", qat(req_log, 0), 32'h200);
    chk("t4_pc0", qat(got_pc, 0), 32'h200);
    chk("t4_pc1", qat(got_pc, 1), 32'h204);
    // 5: PC wraps past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    run(15);
    chk("t5_req0", qat(req_log, 0), 32'hFFFF_FFFC);
    chk("t5_req1_wrap", qat(req_log, 1), 32'h0);
    chk("t5_req2", qat(req_log, 2), 32'h4);
    chk("t5_pc0", qat(got_pc, 0), 32'hFFFF_FFFC);
    chk("t5_pc1", qat(got_pc, 1), 32'h0);
    chk("t5_ins1", qat(got_ins, 1), instr_of(32'h0));
    // 6: asynchronous reset in the middle of a drain
    rsp_en = 1'b0;
    run(6);
    #1;
    chk("t6_outstanding", pend.size(), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    rsp_en = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t6_drain_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6");
    pend.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    rsp_en = 1'b1;
    run(2);
    rst_n = 1'b1;
    clear_logs();
    run(12);
    chk("t6_req0", qat(req_log, 0), 32'h0);
    chk("t6_pc0", qat(got_pc, 0), 32'h0);
    chk("t6_pc1", qat(got_pc, 1), 32'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
